// File: rtl/sqwave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sqwave_pkg
//  Description : Shared types and default constants for the multi-channel
//                square-wave generator (channel state encoding and default
//                parameter values).
//  Revision    : 1.0 - initial release
// ============================================================================
package sqwave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } sqw_state_e;

    localparam int SQW_DEF_CH       = 4;
    localparam int SQW_DEF_WIDTH    = 8;
    localparam int SQW_DEF_TICK_DIV = 10;

endpackage : sqwave_pkg
`default_nettype wire

// File: rtl/sqwave_channel.sv
`default_nettype none
// ============================================================================
//  Module      : sqwave_channel
//  Description : One square-wave channel: IDLE/HIGH/LOW FSM, WIDTH-bit phase
//                counter and a shadow m/n pair that is refreshed only at the
//                start of a run or at a period reload.
//  Ports       : clk, reset_n (async, active-low), tick (shared time-unit
//                strobe), en, m, n (phase lengths in units), signal (registered
//                output), period_done (only with SQW_PERIOD_DONE_EN).
//  Config      : SQW_PERIOD_DONE_EN adds the period_done pulse output.
//  Revision    : 1.0 - initial release
// ============================================================================
module sqwave_channel
    import sqwave_pkg::*;
#(
    parameter int WIDTH = SQW_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             en,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] n,
    output logic             signal
`ifdef SQW_PERIOD_DONE_EN
    ,
    output logic             period_done
`endif
);

    sqw_state_e       r_state;
    sqw_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_m_s;
    logic [WIDTH-1:0] w_m_s_nxt;
    logic [WIDTH-1:0] r_n_s;
    logic [WIDTH-1:0] w_n_s_nxt;
    logic             r_signal;
    logic             w_start;
    logic             w_reload;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_m_s_nxt   = r_m_s;
        w_n_s_nxt   = r_n_s;
        w_start     = 1'b0;
        w_reload    = 1'b0;

        // Disable wins over a coincident tick.
        if (!en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (tick) begin
            case (r_state)
                IDLE: w_start = 1'b1;
                HIGH: begin
                    if (r_cnt == r_m_s - WIDTH'(1)) begin
                        w_cnt_nxt = '0;
                        if (r_n_s == '0) begin
                            w_reload = 1'b1;
                        end else begin
                            w_state_nxt = LOW;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + WIDTH'(1);
                    end
                end
                LOW: begin
                    if (r_cnt == r_n_s - WIDTH'(1)) begin
                        w_reload = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + WIDTH'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase

            // Start and reload share the same entry branch on freshly
            // sampled shadow values; a zero-length phase is skipped.
            if (w_start || w_reload) begin
                w_m_s_nxt = m;
                w_n_s_nxt = n;
                w_cnt_nxt = '0;
                if (m != '0) begin
                    w_state_nxt = HIGH;
                end else if (n != '0) begin
                    w_state_nxt = LOW;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_m_s    <= '0;
            r_n_s    <= '0;
            r_signal <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_m_s    <= w_m_s_nxt;
            r_n_s    <= w_n_s_nxt;
            r_signal <= (w_state_nxt == HIGH);
        end
    end

    assign signal = r_signal;

`ifdef SQW_PERIOD_DONE_EN
    logic r_period_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period_done <= 1'b0;
        end else begin
            r_period_done <= w_reload;
        end
    end

    assign period_done = r_period_done;
`endif

endmodule : sqwave_channel
`default_nettype wire

// File: rtl/multi_sqwave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : multi_sqwave_gen
//  Description : CH-channel programmable square-wave generator. Holds the
//                shared time-unit prescaler and one sqwave_channel per
//                channel. Channel i uses en[i], m[i*WIDTH +: WIDTH] and
//                n[i*WIDTH +: WIDTH].
//  Ports       : clk, reset_n (async, active-low), en[CH], m/n[CH*WIDTH],
//                signal[CH], period_done[CH] (only with SQW_PERIOD_DONE_EN).
//  Config      : SQW_PERIOD_DONE_EN adds the period_done output.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_sqwave_gen
    import sqwave_pkg::*;
#(
    parameter int CH       = SQW_DEF_CH,
    parameter int WIDTH    = SQW_DEF_WIDTH,
    parameter int TICK_DIV = SQW_DEF_TICK_DIV
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CH-1:0]       en,
    input  logic [CH*WIDTH-1:0] m,
    input  logic [CH*WIDTH-1:0] n,
    output logic [CH-1:0]       signal
`ifdef SQW_PERIOD_DONE_EN
    ,
    output logic [CH-1:0]       period_done
`endif
);

    // At least one bit so TICK_DIV=1 still builds; the counter then stays 0.
    localparam int C_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [C_PW-1:0] r_pre;
    logic            w_tick;

    assign w_tick = (r_pre == C_PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + C_PW'(1);
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        sqwave_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk         (clk),
            .reset_n     (reset_n),
            .tick        (w_tick),
            .en          (en[gi]),
            .m           (m[gi*WIDTH +: WIDTH]),
            .n           (n[gi*WIDTH +: WIDTH]),
            .signal      (signal[gi])
`ifdef SQW_PERIOD_DONE_EN
            ,
            .period_done (period_done[gi])
`endif
        );
    end

endmodule : multi_sqwave_gen
`default_nettype wire

// File: tb/tb_multi_sqwave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_sqwave_gen
//  Description : Self-checking bench for multi_sqwave_gen. A behavioural model
//                tracks each channel as a phase plus remaining time units and
//                predicts signal/period_done every cycle; directed scenarios
//                also measure phase lengths directly in clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_sqwave_gen;

    localparam int CH    = 4;
    localparam int WIDTH = 8;
    localparam int TD    = 10;

    logic                clk     = 1'b0;
    logic                reset_n = 1'b0;
    logic [CH-1:0]       en      = '0;
    logic [CH*WIDTH-1:0] m       = '0;
    logic [CH*WIDTH-1:0] n       = '0;
    logic [CH-1:0]       signal;
`ifdef SQW_PERIOD_DONE_EN
    logic [CH-1:0]       period_done;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_sqwave_gen #(
        .CH       (CH),
        .WIDTH    (WIDTH),
        .TICK_DIV (TD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .m           (m),
        .n           (n),
        .signal      (signal)
`ifdef SQW_PERIOD_DONE_EN
        ,
        .period_done (period_done)
`endif
    );

    // ------------------------------------------------------------------
    // Reference model: phase 0=off, 1=high, 2=low; rem = units left.
    // ------------------------------------------------------------------
    int            md_ph  [CH] = '{default: 0};
    int            md_rem [CH] = '{default: 0};
    int            md_ms  [CH] = '{default: 0};
    int            md_ns  [CH] = '{default: 0};
    int            md_cyc      = 0;
    bit            md_tk;
    bit            md_rs;
    logic [CH-1:0] exp_sig = '0;
    logic [CH-1:0] exp_pd  = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cyc  = 0;
            exp_sig = '0;
            exp_pd  = '0;
            for (int c = 0; c < CH; c++) begin
                md_ph[c] = 0; md_rem[c] = 0; md_ms[c] = 0; md_ns[c] = 0;
            end
        end else begin
            md_tk  = ((md_cyc % TD) == TD - 1);
            md_cyc = md_cyc + 1;
            for (int c = 0; c < CH; c++) begin
                exp_pd[c] = 1'b0;
                md_rs     = 1'b0;
                if (!en[c]) begin
                    md_ph[c] = 0;
                end else if (md_tk) begin
                    if (md_ph[c] == 0) begin
                        md_rs = 1'b1;
                    end else begin
                        md_rem[c] = md_rem[c] - 1;
                        if (md_rem[c] == 0) begin
                            if (md_ph[c] == 1 && md_ns[c] > 0) begin
                                md_ph[c]  = 2;
                                md_rem[c] = md_ns[c];
                            end else begin
                                md_rs     = 1'b1;
                                exp_pd[c] = 1'b1;
                            end
                        end
                    end
                    if (md_rs) begin
                        md_ms[c] = int'(m[c*WIDTH +: WIDTH]);
                        md_ns[c] = int'(n[c*WIDTH +: WIDTH]);
                        if (md_ms[c] > 0) begin
                            md_ph[c] = 1; md_rem[c] = md_ms[c];
                        end else if (md_ns[c] > 0) begin
                            md_ph[c] = 2; md_rem[c] = md_ns[c];
                        end else begin
                            md_ph[c] = 0;
                        end
                    end
                end
                exp_sig[c] = (md_ph[c] == 1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus/measurement utilities (no checking inside)
    // ------------------------------------------------------------------
    task automatic set_ch(input int c, input int mv, input int nv);
        m[c*WIDTH +: WIDTH] = WIDTH'(mv);
        n[c*WIDTH +: WIDTH] = WIDTH'(nv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until signal[c] equals lvl; waited = steps taken (max = timeout).
    task automatic wait_lvl(input int c, input logic lvl, input int max, output int waited);
        waited = 0;
        while (signal[c] !== lvl && waited < max) begin
            step();
            waited++;
        end
    endtask

    // Counts cycles for which signal[c] stays at lvl (bounded).
    task automatic run_len(input int c, input logic lvl, output int len);
        len = 0;
        while (signal[c] === lvl && len < 2000) begin
            step();
            len++;
        end
    endtask

    task automatic quiesce();
        @(negedge clk);
        en = '0;
        m  = '0;
        n  = '0;
        step();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if (signal !== '0) begin
            failures++;
            $display("FAIL reset_signal got=%b exp=%b", signal, {CH{1'b0}});
        end
`ifdef SQW_PERIOD_DONE_EN
        checks++;
        if (period_done !== '0) begin
            failures++;
            $display("FAIL reset_pd got=%b exp=%b", period_done, {CH{1'b0}});
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        // Disabled channels must stay quiet.
        repeat (25) begin
            step();
            checks++;
            if (signal !== '0) begin
                failures++;
                $display("FAIL idle_disabled got=%b exp=%b", signal, {CH{1'b0}});
            end
        end
    endtask

    task automatic test_single();
        int w, len;
        quiesce();
        @(negedge clk);
        set_ch(0, 1, 1);
        en[0] = 1'b1;
        wait_lvl(0, 1'b1, 30, w);
        checks++;
        if (w >= 30) begin
            failures++;
            $display("FAIL single_start timeout waited=%0d limit=30", w);
        end
        for (int k = 0; k < 2; k++) begin
            run_len(0, 1'b1, len);
            checks++;
            if (len !== 10) begin
                failures++;
                $display("FAIL single_high got=%0d exp=10", len);
            end
            run_len(0, 1'b0, len);
            checks++;
            if (len !== 10) begin
                failures++;
                $display("FAIL single_low got=%0d exp=10", len);
            end
        end
        repeat (60) begin
            step();
            checks++;
            if (signal !== exp_sig) begin
                failures++;
                $display("FAIL single_model t=%0t got=%b exp=%b", $time, signal, exp_sig);
            end
`ifdef SQW_PERIOD_DONE_EN
            checks++;
            if (period_done !== exp_pd) begin
                failures++;
                $display("FAIL single_pd t=%0t got=%b exp=%b", $time, period_done, exp_pd);
            end
`endif
        end
    endtask

    task automatic test_multi();
        int w, len;
        quiesce();
        @(negedge clk);
        set_ch(1, 4, 3);
        set_ch(2, 2, 2);
        en = 4'b0110;
        repeat (200) begin
            step();
            checks++;
            if (signal !== exp_sig) begin
                failures++;
                $display("FAIL multi_model t=%0t got=%b exp=%b", $time, signal, exp_sig);
            end
`ifdef SQW_PERIOD_DONE_EN
            checks++;
            if (period_done !== exp_pd) begin
                failures++;
                $display("FAIL multi_pd t=%0t got=%b exp=%b", $time, period_done, exp_pd);
            end
`endif
        end
        wait_lvl(1, 1'b0, 100, w);
        wait_lvl(1, 1'b1, 100, w);
        run_len(1, 1'b1, len);
        checks++;
        if (len !== 40) begin
            failures++;
            $display("FAIL multi_ch1_high got=%0d exp=40", len);
        end
        run_len(1, 1'b0, len);
        checks++;
        if (len !== 30) begin
            failures++;
            $display("FAIL multi_ch1_low got=%0d exp=30", len);
        end
        wait_lvl(2, 1'b0, 100, w);
        wait_lvl(2, 1'b1, 100, w);
        run_len(2, 1'b1, len);
        checks++;
        if (len !== 20) begin
            failures++;
            $display("FAIL multi_ch2_high got=%0d exp=20", len);
        end
        run_len(2, 1'b0, len);
        checks++;
        if (len !== 20) begin
            failures++;
            $display("FAIL multi_ch2_low got=%0d exp=20", len);
        end
    endtask

    task automatic test_shadow();
        int w, len;
        quiesce();
        @(negedge clk);
        set_ch(0, 4, 3);
        en[0] = 1'b1;
        wait_lvl(0, 1'b1, 30, w);
        repeat (15) step();
        @(negedge clk);
        set_ch(0, 2, 2);
        run_len(0, 1'b1, len);
        checks++;
        if (len + 15 !== 40) begin
            failures++;
            $display("FAIL shadow_cur_high got=%0d exp=40", len + 15);
        end
        run_len(0, 1'b0, len);
        checks++;
        if (len !== 30) begin
            failures++;
            $display("FAIL shadow_cur_low got=%0d exp=30", len);
        end
        run_len(0, 1'b1, len);
        checks++;
        if (len !== 20) begin
            failures++;
            $display("FAIL shadow_next_high got=%0d exp=20", len);
        end
        run_len(0, 1'b0, len);
        checks++;
        if (len !== 20) begin
            failures++;
            $display("FAIL shadow_next_low got=%0d exp=20", len);
        end
    endtask

    task automatic test_edge_cases();
        int hi0, hi2, lo1;
`ifdef SQW_PERIOD_DONE_EN
        int pd0, pd1, pd2;
        pd0 = 0; pd1 = 0; pd2 = 0;
`endif
        hi0 = 0; hi2 = 0; lo1 = 0;
        quiesce();
        @(negedge clk);
        set_ch(0, 0, 5);
        set_ch(1, 3, 0);
        set_ch(2, 0, 0);
        set_ch(3, 1, 2);
        en = 4'b1111;
        for (int cyc = 0; cyc < 320; cyc++) begin
            step();
            checks++;
            if (signal !== exp_sig) begin
                failures++;
                $display("FAIL edge_model t=%0t got=%b exp=%b", $time, signal, exp_sig);
            end
`ifdef SQW_PERIOD_DONE_EN
            checks++;
            if (period_done !== exp_pd) begin
                failures++;
                $display("FAIL edge_pd t=%0t got=%b exp=%b", $time, period_done, exp_pd);
            end
            if (cyc >= 20) begin
                pd0 += int'(period_done[0]);
                pd1 += int'(period_done[1]);
                pd2 += int'(period_done[2]);
            end
`endif
            if (signal[0]) hi0++;
            if (signal[2]) hi2++;
            if (cyc >= 20 && !signal[1]) lo1++;
        end
        checks++;
        if (hi0 !== 0) begin
            failures++;
            $display("FAIL edge_m0_high got=%0d exp=0", hi0);
        end
        checks++;
        if (lo1 !== 0) begin
            failures++;
            $display("FAIL edge_n0_low got=%0d exp=0", lo1);
        end
        checks++;
        if (hi2 !== 0) begin
            failures++;
            $display("FAIL edge_00_high got=%0d exp=0", hi2);
        end
`ifdef SQW_PERIOD_DONE_EN
        // 300 cycles observed: every 50 cycles on ch0, every 30 on ch1.
        checks++;
        if (pd0 !== 6) begin
            failures++;
            $display("FAIL edge_m0_pd got=%0d exp=6", pd0);
        end
        checks++;
        if (pd1 !== 10) begin
            failures++;
            $display("FAIL edge_n0_pd got=%0d exp=10", pd1);
        end
        checks++;
        if (pd2 !== 0) begin
            failures++;
            $display("FAIL edge_00_pd got=%0d exp=0", pd2);
        end
`endif
    endtask

    task automatic test_async_reset();
        int w;
        quiesce();
        @(negedge clk);
        set_ch(0, 3, 2);
        en[0] = 1'b1;
        wait_lvl(0, 1'b1, 30, w);
        repeat (5) step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (signal !== '0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", signal, {CH{1'b0}});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_lvl(0, 1'b1, 30, w);
        checks++;
        if (w !== TD) begin
            failures++;
            $display("FAIL async_restart_delay got=%0d exp=%0d", w, TD);
        end
        repeat (80) begin
            step();
            checks++;
            if (signal !== exp_sig) begin
                failures++;
                $display("FAIL async_model t=%0t got=%b exp=%b", $time, signal, exp_sig);
            end
        end
    endtask

    task automatic test_enable_drop();
        int w, len;
        quiesce();
        @(negedge clk);
        set_ch(0, 2, 2);
        en[0] = 1'b1;
        // Drop during HIGH: output must fall on the very next edge.
        wait_lvl(0, 1'b1, 30, w);
        repeat (3) step();
        @(negedge clk);
        en[0] = 1'b0;
        step();
        checks++;
        if (signal[0] !== 1'b0) begin
            failures++;
            $display("FAIL en_drop_high got=%b exp=0", signal[0]);
        end
        // Re-enable, then drop during LOW.
        @(negedge clk);
        en[0] = 1'b1;
        wait_lvl(0, 1'b1, 30, w);
        run_len(0, 1'b1, len);
        repeat (5) step();
        @(negedge clk);
        en[0] = 1'b0;
        repeat (17) begin
            step();
            checks++;
            if (signal !== exp_sig) begin
                failures++;
                $display("FAIL en_drop_model t=%0t got=%b exp=%b", $time, signal, exp_sig);
            end
        end
        @(negedge clk);
        en[0] = 1'b1;
        wait_lvl(0, 1'b1, 30, w);
        checks++;
        if (w > TD) begin
            failures++;
            $display("FAIL en_restart_delay got=%0d exp<=%0d", w, TD);
        end
        run_len(0, 1'b1, len);
        checks++;
        if (len !== 20) begin
            failures++;
            $display("FAIL en_restart_high got=%0d exp=20", len);
        end
    endtask

    task automatic test_random();
        int chg;
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                set_ch(c, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
                en[c] = ($urandom_range(0, 4) != 0);
            end
            chg = int'($urandom_range(20, 180));
            for (int cyc = 0; cyc < 200; cyc++) begin
                if (cyc == chg) begin
                    @(negedge clk);
                    set_ch(int'($urandom_range(0, CH - 1)),
                           int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
                    if ($urandom_range(0, 3) == 0)
                        en[$urandom_range(0, CH - 1)] = 1'b0;
                end
                step();
                checks++;
                if (signal !== exp_sig) begin
                    failures++;
                    $display("FAIL rand_model r=%0d cyc=%0d got=%b exp=%b", r, cyc, signal, exp_sig);
                end
`ifdef SQW_PERIOD_DONE_EN
                checks++;
                if (period_done !== exp_pd) begin
                    failures++;
                    $display("FAIL rand_pd r=%0d cyc=%0d got=%b exp=%b", r, cyc, period_done, exp_pd);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_shadow();
        test_edge_cases();
        test_async_reset();
        test_enable_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_multi_sqwave_gen
`default_nettype wire
